// File: rtl/mvu_pe_acc_pkg.sv
// Shared MVAU definitions for the PE accumulator slice.
// Provides the default lane count, word lengths and synapse fold used by
// mvu_pe_acc and mvu_pe_adders, plus a counter-width helper.
package mvu_pe_acc_pkg;

    // Source activation and weight word lengths of the MVAU.
    localparam int unsigned TSrcI = 4;
    localparam int unsigned TW    = 1;

    // PE datapath defaults.
    localparam int unsigned MVU_SIMD  = 2;
    localparam int unsigned MVU_TDSTI = 4;
    localparam int unsigned MVU_SF    = 4;
    localparam int unsigned MVU_TDSTA = 16;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvu_pe_adders.sv
// Combinational lane reduction for one PE.
// Ports:
//   in_simd : packed signed lane products, lane 0 in the LSBs
//   sum_c   : sign-extended sum of all lanes, wrapping at TDstA bits
module mvu_pe_adders
    import mvu_pe_acc_pkg::*;
#(
    parameter int unsigned SIMD  = MVU_SIMD,
    parameter int unsigned TDstI = MVU_TDSTI,
    parameter int unsigned TDstA = MVU_TDSTA
) (
    input  logic [SIMD*TDstI-1:0] in_simd,
    output logic [TDstA-1:0]      sum_c
);

    // Sign-extend every lane to the accumulator width and add them up.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(SIMD); i++) begin
            sum_c = sum_c + TDstA'($signed(in_simd[i*TDstI +: TDstI]));
        end
    end

endmodule

// File: rtl/mvu_pe_acc.sv
// MVAU processing-element accumulator.
// Reduces SIMD lane products per beat, then accumulates SF beats into one
// signed dot product. Two register stages: lane sum, then accumulator/output.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   do_mvau_stream  : pipeline enable; low freezes all state
//   in_v, in_simd   : product beat valid and packed signed lane products
//   out_v, out      : one-cycle completion pulse and registered dot product
module mvu_pe_acc
    import mvu_pe_acc_pkg::*;
#(
    parameter int unsigned SIMD  = MVU_SIMD,
    parameter int unsigned TDstI = MVU_TDSTI,
    parameter int unsigned SF    = MVU_SF,
    parameter int unsigned TDstA = MVU_TDSTA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  do_mvau_stream,
    input  logic                  in_v,
    input  logic [SIMD*TDstI-1:0] in_simd,
    output logic                  out_v,
    output logic [TDstA-1:0]      out
);

    localparam int unsigned CNT_W = cnt_width(SF);
    localparam logic [CNT_W-1:0] SF_LAST = CNT_W'(SF - 1);

    logic [TDstA-1:0] sum_c;
    logic [TDstA-1:0] sum_r;
    logic             sum_v;
    logic [TDstA-1:0] acc;
    logic [CNT_W-1:0] sf_cnt;
    logic [TDstA-1:0] acc_nxt_c;

    mvu_pe_adders #(
        .SIMD  (SIMD),
        .TDstI (TDstI),
        .TDstA (TDstA)
    ) u_adders (
        .in_simd (in_simd),
        .sum_c   (sum_c)
    );

    // First beat of a fold restarts from zero, so back-to-back products need no gap.
    assign acc_nxt_c = ((sf_cnt == '0) ? '0 : acc) + sum_r;

    // Stage 1: registered lane sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r <= '0;
            sum_v <= 1'b0;
        end else if (do_mvau_stream) begin
            sum_r <= sum_c;
            sum_v <= in_v;
        end
    end

    // Stage 2: fold accumulation and completion pulse; a stalled pulse is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            sf_cnt <= '0;
            out    <= '0;
            out_v  <= 1'b0;
        end else if (do_mvau_stream) begin
            out_v <= 1'b0;
            if (sum_v) begin
                acc <= acc_nxt_c;
                if (sf_cnt == SF_LAST) begin
                    sf_cnt <= '0;
                    out    <= acc_nxt_c;
                    out_v  <= 1'b1;
                end else begin
                    sf_cnt <= sf_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Scoreboard bench for mvu_pe_acc: three configurations share one stimulus
// stream (default, SF=1, and a 6-bit accumulator that wraps).
module tb_mvu_pe_acc;

    localparam int NI = 3;
    localparam int SF_OF [NI] = '{4, 1, 4};
    localparam int W_OF  [NI] = '{16, 16, 6};

    typedef struct {
        int val;
        int stamp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_v;
    logic [7:0]  in_simd;
    logic        ov_a, ov_b, ov_c;
    logic [15:0] out_a, out_b;
    logic [5:0]  out_c;

    mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(4), .TDstA(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .do_mvau_stream(en), .in_v(in_v),
        .in_simd(in_simd), .out_v(ov_a), .out(out_a));

    mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(1), .TDstA(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .do_mvau_stream(en), .in_v(in_v),
        .in_simd(in_simd), .out_v(ov_b), .out(out_b));

    mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(4), .TDstA(6)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .do_mvau_stream(en), .in_v(in_v),
        .in_simd(in_simd), .out_v(ov_c), .out(out_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    exp_t q [NI][$];
    int   last_out [NI];
    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;

    // Reference model state: beats waiting one cycle, then per-fold partial sums
    bit   pv   [NI];
    int   pend [NI];
    int   cnt  [NI];
    int   accm [NI];

    int   dout [NI];
    logic dv   [NI];

    always_comb begin
        dout[0] = 32'($signed(out_a));
        dout[1] = 32'($signed(out_b));
        dout[2] = 32'($signed(out_c));
        dv[0]   = ov_a;
        dv[1]   = ov_b;
        dv[2]   = ov_c;
    end

    function automatic int wrap(input int v, input int w);
        int sh;
        sh = 32 - w;
        return (v <<< sh) >>> sh;
    endfunction

    // Reference model: advance by the upcoming clock edge.
    function automatic void model_step(input int l0, input int l1);
        int up;
        up = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                q[k].delete();
                pv[k]   = 1'b0;
                cnt[k]  = 0;
                accm[k] = 0;
            end else if (en) begin
                if (pv[k]) begin
                    accm[k] += pend[k];
                    cnt[k]++;
                    if (cnt[k] == SF_OF[k]) begin
                        q[k].push_back('{val: wrap(accm[k], W_OF[k]), stamp: up});
                        cnt[k]  = 0;
                        accm[k] = 0;
                    end
                end
                pv[k]   = in_v;
                pend[k] = l0 + l1;
            end
        end
    endfunction

    task automatic drive(input int l0, input int l1, input bit v, input bit e, input bit r);
        @(negedge clk);
        in_simd = {4'(l1), 4'(l0)};
        in_v    = v;
        en      = e;
        rst_n   = r;
        model_step(l0, l1);
    endtask

    task automatic beat(input int l0, input int l1);
        drive(l0, l1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic stall();
        drive(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are consumed at enabled edges; checks value, timing and hold.
    always @(posedge clk) begin
        exp_t e;
        bit   have;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                last_out[k] = 0;
            end else if (en) begin
                have = (q[k].size() > 0) && (q[k][0].stamp < cyc);
                nvec++;
                if (dv[k]) begin
                    if (!have) begin
                        nfail++;
                        $display("FAIL spurious_out_v inst%0d cyc%0d: out_v=1 out=%0d, expected out_v=0",
                                 k, cyc, dout[k]);
                    end else begin
                        e = q[k].pop_front();
                        last_out[k] = e.val;
                        if (dout[k] != e.val) begin
                            nfail++;
                            $display("FAIL out_value inst%0d cyc%0d: got %0d, expected %0d",
                                     k, cyc, dout[k], e.val);
                        end
                    end
                end else if (have) begin
                    e = q[k].pop_front();
                    last_out[k] = e.val;
                    nfail++;
                    $display("FAIL missing_out_v inst%0d cyc%0d: out_v=0, expected out_v=1 out=%0d",
                             k, cyc, e.val);
                end else if (dout[k] != last_out[k]) begin
                    nfail++;
                    $display("FAIL out_hold inst%0d cyc%0d: got %0d, expected %0d",
                             k, cyc, dout[k], last_out[k]);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        in_v    = 1'b0;
        in_simd = '0;
        for (int k = 0; k < NI; k++) begin
            pv[k] = 1'b0; pend[k] = 0; cnt[k] = 0; accm[k] = 0; last_out[k] = 0;
        end
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        idle(); idle();

        // Basic dot product: 5
        beat(1, 2); beat(3, -1); beat(-4, 0); beat(2, 2);
        repeat (4) idle();

        // Same with bubbles, a mid-stream stall and a stall over the pending pulse
        beat(1, 2); idle(); beat(3, -1);
        stall(); stall(); stall();
        beat(-4, 0); idle(); beat(2, 2); idle();
        stall(); stall(); stall();
        repeat (3) idle();

        // Back-to-back: 56 then -64 (6-bit instance wraps to -8 then 0)
        repeat (4) beat(7, 7);
        repeat (4) beat(-8, -8);
        repeat (4) idle();

        // Reset mid-fold with enable low, then a fresh fold of ones: 8
        beat(1, 1); beat(1, 1);
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) beat(1, 1);
        repeat (4) idle();

        // SF=1 extreme beat
        beat(-8, -8); beat(-8, -8);
        repeat (4) idle();

        // Randomized traffic with stalls, bubbles and rare resets
        for (int i = 0; i < 600; i++) begin
            drive(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                  $urandom_range(99) < 70, $urandom_range(99) < 85,
                  $urandom_range(199) != 0);
        end

        repeat (8) idle();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            nvec++;
            if (q[k].size() != 0) begin
                nfail++;
                $display("FAIL drain inst%0d: %0d results outstanding, expected 0", k, q[k].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mvu_pe_acc.md
MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 Parameter SIMD, default 2: number of SIMD product lanes per PE.
REQ-002 Parameter TDstI, default 4: word length of each signed SIMD product.
REQ-003 Parameter SF, default 4: synapse fold, i.e. product beats accumulated per output.
REQ-004 Parameter TDstA, default 16: accumulator and output word length; SHALL satisfy TDstA >= TDstI + clog2(SIMD*SF).
REQ-005 clk  input  1: clock.
REQ-006 rst_n  input  1: reset, synchronous, active-low.
REQ-007 do_mvau_stream  input  1: pipeline enable; low freezes every register in the block.
REQ-008 in_v  input  1: SIMD product beat valid.
REQ-009 in_simd  input  SIMD*TDstI: packed signed lane products, lane 0 in the LSBs.
REQ-010 out_v  output  1: one-cycle pulse marking a completed dot product.
REQ-011 out  output  TDstA: signed accumulated dot product.

Function
REQ-012 Stage 1 SHALL sign-extend each lane to TDstA and register the lane sum as sum_r, with validity flag sum_v <= in_v, when do_mvau_stream=1.
REQ-013 Stage 2 SHALL act on sum_v=1 with do_mvau_stream=1: acc <= (sf_cnt==0 ? 0 : acc) + sum_r.
REQ-014 sf_cnt SHALL count accepted stage-2 beats from 0 to SF-1, then wrap to 0 on the next accepted beat.
REQ-015 On an accepted beat with sf_cnt==SF-1, out SHALL register the new acc value and out_v SHALL be 1 for exactly that cycle.
REQ-016 out_v SHALL be 0 in every other cycle.
REQ-017 out SHALL hold its last value until the next completion.
REQ-018 Latency SHALL be 2 enabled cycles: last product beat at enabled edge t gives out_v=1 after enabled edge t+2.
REQ-019 When do_mvau_stream=0, sum_r, sum_v, acc, sf_cnt, out and out_v SHALL hold; a pending out_v=1 SHALL remain asserted while stalled.
REQ-020 When in_v=0 with do_mvau_stream=1, sum_v SHALL become 0, and acc and sf_cnt SHALL hold (bubble tolerance).
REQ-021 All arithmetic SHALL be two's complement, wrapping modulo 2^TDstA with no saturation.
REQ-022 With SF=1, every accepted beat SHALL produce out = sum_r with out_v=1.
REQ-023 Back-to-back dot products SHALL need no idle cycle: the beat after a completion starts a fresh accumulation from 0.

Reset
REQ-024 With rst_n=0 at a clk edge, sum_r, sum_v, acc, sf_cnt, out and out_v SHALL all become 0, regardless of do_mvau_stream.
REQ-025 Reset mid-accumulation SHALL discard partial sums; the first beat after reset SHALL be treated as sf_cnt==0.

Structure
REQ-026 SIMD, TDstI, SF and TDstA SHALL come from the shared MVAU definitions package alongside TSrcI and TW; sf_cnt width SHALL be clog2(SF) with a minimum of 1.
REQ-027 The lane sign-extension and adder tree SHALL be one combinational sub-module, mvu_pe_adders, with stage-1 registers in mvu_pe_acc.
REQ-028 The block SHALL contain no other sub-modules or memories.

Verification
REQ-029 SIMD=2, SF=4, do_mvau_stream=1; four beats of lanes (1,2),(3,-1),(-4,0),(2,2) -> single out_v pulse with out=5 two cycles after the fourth beat.
REQ-030 Same stimulus with in_v=0 bubbles between beats and do_mvau_stream=0 for 3 cycles mid-stream -> out=5, exactly one out_v pulse, held during stall.
REQ-031 Two back-to-back dot products, all lanes +7 then all lanes -8 -> out=56 then out=-64 on consecutive SF-spaced pulses.
REQ-032 rst_n=0 for one cycle after two beats -> no output; next four beats of all-1 lanes -> out=8.
REQ-033 SF=1, beat (-8,-8) -> out=-16, out_v=1 every beat.
REQ-034 TDstA=6, SF=4, all lanes +7 (sum 56) -> out=-8, wrap-around check.
